// File: rtl/minibyte_mem_arbiter_pkg.sv
// Shared definitions for the minibyte memory-bus arbiter: FSM state encoding and bus width defaults.
package minibyte_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/minibyte_rr_arb2.sv
// Combinational two-way round-robin pick; the priority pointer is held by the parent.
module minibyte_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic sel,
  output logic valid
);

  assign valid = req0 | req1;
  // A lone requester wins outright; the pointer only breaks ties.
  assign sel   = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/minibyte_mem_arbiter.sv
// Shares the external memory bus between the CPU (port 0) and the debug/DMA loader (port 1),
// running each access through a fixed IDLE -> ACCESS -> DONE window with registered bus outputs.
module minibyte_mem_arbiter
  import minibyte_mem_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_drive,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  state_t           state, state_nxt;
  logic             ptr;
  logic             owner;
  logic             sel;
  logic             sel_valid;
  logic [CNT_W-1:0] cnt;

  minibyte_rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .sel   (sel),
    .valid (sel_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (sel_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus, owner and ack registers; ack defaults low so it pulses only in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            owner     <= sel;
            ptr       <= ~sel;
            cnt       <= CNT_W'(WAIT_STATES);
            bus_addr  <= sel ? addr1 : addr0;
            bus_wdata <= sel ? wdata1 : wdata0;
            bus_we    <= sel ? we1 : we0;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!bus_we) rdata <= bus_rdata;
            ack0   <= ~owner;
            ack1   <= owner;
            bus_we <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign gnt0      = busy & ~owner;
  assign gnt1      = busy & owner;
  assign bus_drive = bus_we;

endmodule

// File: tb/tb_minibyte_mem_arbiter.sv
// Bench for minibyte_mem_arbiter: two builds (WAIT_STATES=1 and 0) share stimulus and are checked
// every cycle against an access-age model, plus directed literal checks.
module tb_minibyte_mem_arbiter;

  localparam int WS_A = 1;
  localparam int WS_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0, bus_rdata = '0;

  logic [1:0] o_gnt0, o_gnt1, o_ack0, o_ack1, o_bus_we, o_bus_drive, o_busy;
  logic [7:0] o_rdata     [2];
  logic [6:0] o_bus_addr  [2];
  logic [7:0] o_bus_wdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  minibyte_mem_arbiter #(.WAIT_STATES(WS_A), .ADDR_W(7), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .gnt0(o_gnt0[0]), .ack0(o_ack0[0]),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .gnt1(o_gnt1[0]), .ack1(o_ack1[0]),
    .rdata(o_rdata[0]), .bus_addr(o_bus_addr[0]), .bus_wdata(o_bus_wdata[0]),
    .bus_we(o_bus_we[0]), .bus_drive(o_bus_drive[0]), .bus_rdata(bus_rdata), .busy(o_busy[0])
  );

  minibyte_mem_arbiter #(.WAIT_STATES(WS_B), .ADDR_W(7), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .gnt0(o_gnt0[1]), .ack0(o_ack0[1]),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .gnt1(o_gnt1[1]), .ack1(o_ack1[1]),
    .rdata(o_rdata[1]), .bus_addr(o_bus_addr[1]), .bus_wdata(o_bus_wdata[1]),
    .bus_we(o_bus_we[1]), .bus_drive(o_bus_drive[1]), .bus_rdata(bus_rdata), .busy(o_busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? WS_A : WS_B;
  endfunction

  function automatic logic winner(input logic r0, input logic r1, input logic p);
    if (r0 && r1) return p;
    return r1;
  endfunction

  // Model: m_age counts cycles since the grant (0 = idle). Ages 1..WS+1 are the bus window,
  // age WS+2 is the ack cycle, after which the port is idle again.
  int         m_age   [2];
  logic       m_owner [2];
  logic       m_ptr   [2];
  logic       m_we    [2];
  logic [6:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_age[i] <= 0; m_owner[i] <= 1'b0; m_ptr[i] <= 1'b0; m_we[i] <= 1'b0;
        m_addr[i] <= '0; m_wdata[i] <= '0; m_rdata[i] <= '0;
      end else if (m_age[i] == 0) begin
        if (req0 || req1) begin
          m_owner[i] <= winner(req0, req1, m_ptr[i]);
          m_ptr[i]   <= !winner(req0, req1, m_ptr[i]);
          m_addr[i]  <= winner(req0, req1, m_ptr[i]) ? addr1 : addr0;
          m_wdata[i] <= winner(req0, req1, m_ptr[i]) ? wdata1 : wdata0;
          m_we[i]    <= winner(req0, req1, m_ptr[i]) ? we1 : we0;
          m_age[i]   <= 1;
        end
      end else begin
        if (m_age[i] == ws_of(i) + 1 && !m_we[i]) m_rdata[i] <= bus_rdata;
        m_age[i] <= (m_age[i] == ws_of(i) + 2) ? 0 : m_age[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_we;
      e_we = m_we[i] && m_age[i] >= 1 && m_age[i] <= ws_of(i) + 1;
      chk($sformatf("m%0d gnt0", i), o_gnt0[i], m_age[i] != 0 && !m_owner[i]);
      chk($sformatf("m%0d gnt1", i), o_gnt1[i], m_age[i] != 0 && m_owner[i]);
      chk($sformatf("m%0d ack0", i), o_ack0[i], m_age[i] == ws_of(i) + 2 && !m_owner[i]);
      chk($sformatf("m%0d ack1", i), o_ack1[i], m_age[i] == ws_of(i) + 2 && m_owner[i]);
      chk($sformatf("m%0d busy", i), o_busy[i], m_age[i] != 0);
      chk($sformatf("m%0d bus_we", i), o_bus_we[i], e_we);
      chk($sformatf("m%0d bus_drive", i), o_bus_drive[i], e_we);
      chk($sformatf("m%0d bus_addr", i), o_bus_addr[i], m_addr[i]);
      chk($sformatf("m%0d bus_wdata", i), o_bus_wdata[i], m_wdata[i]);
      chk($sformatf("m%0d rdata", i), o_rdata[i], m_rdata[i]);
      chk($sformatf("m%0d gnt excl", i), o_gnt0[i] & o_gnt1[i], 1'b0);
      chk($sformatf("m%0d ack excl", i), o_ack0[i] & o_ack1[i], 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  int   ack_cyc [8];
  logic ack_own [8];
  int   na;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst busy", o_busy[0], 1'b0);
    chk("rst bus_addr", o_bus_addr[0], 7'h00);
    chk("rst rdata", o_rdata[0], 8'h00);
    chk("rst gnt0", o_gnt0[0], 1'b0);
    rst_n = 1'b1;
    tick();

    // CPU read, WAIT_STATES=1
    req0 = 1; addr0 = 7'h05; we0 = 0; bus_rdata = 8'hA5;
    tick();
    chk("t1 bus_addr c1", o_bus_addr[0], 7'h05);
    chk("t1 gnt0 c1", o_gnt0[0], 1'b1);
    chk("t1 bus_we c1", o_bus_we[0], 1'b0);
    tick();
    chk("t1 bus_addr c2", o_bus_addr[0], 7'h05);
    chk("t1 ack0 c2", o_ack0[0], 1'b0);
    tick();
    chk("t1 ack0 c3", o_ack0[0], 1'b1);
    chk("t1 rdata", o_rdata[0], 8'hA5);
    chk("t1 gnt1", o_gnt1[0], 1'b0);
    clear_inputs();
    tick(); tick(); tick();
    do_reset();

    // Debug write
    req1 = 1; addr1 = 7'h7C; wdata1 = 8'h3C; we1 = 1;
    tick();
    chk("t2 bus_we c1", o_bus_we[0], 1'b1);
    chk("t2 bus_drive c1", o_bus_drive[0], 1'b1);
    chk("t2 bus_wdata", o_bus_wdata[0], 8'h3C);
    chk("t2 bus_addr", o_bus_addr[0], 7'h7C);
    chk("t2 gnt1", o_gnt1[0], 1'b1);
    tick();
    chk("t2 bus_we c2", o_bus_we[0], 1'b1);
    tick();
    chk("t2 ack1", o_ack1[0], 1'b1);
    chk("t2 bus_we ack", o_bus_we[0], 1'b0);
    clear_inputs();
    tick();
    chk("t2 ack1 clear", o_ack1[0], 1'b0);
    tick(); tick();

    // Simultaneous requests held from reset: acks alternate, WAIT_STATES+3 apart
    rst_n = 1'b0;
    req0 = 1; req1 = 1; addr0 = 7'h11; addr1 = 7'h22; bus_rdata = 8'h5C;
    tick(); tick();
    rst_n = 1'b1;
    na = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (o_ack0[0] || o_ack1[0]) begin
        if (na < 8) begin
          ack_cyc[na] = c;
          ack_own[na] = o_ack1[0];
        end
        na++;
      end
    end
    chk("t3 ack count", na, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3 ack%0d cycle", k), ack_cyc[k], 3 + 4 * k);
      chk($sformatf("t3 ack%0d owner", k), ack_own[k], k % 2);
    end
    clear_inputs();
    tick(); tick(); tick(); tick();
    do_reset();

    // Early drop of req0 during ACCESS
    req0 = 1; addr0 = 7'h10; we0 = 0; bus_rdata = 8'h5A;
    tick();
    req0 = 0;
    tick(); tick();
    chk("t4 ack0", o_ack0[0], 1'b1);
    chk("t4 rdata", o_rdata[0], 8'h5A);
    tick();
    chk("t4 gnt0 idle", o_gnt0[0], 1'b0);
    tick();
    chk("t4 gnt0 after", o_gnt0[0], 1'b0);
    chk("t4 busy after", o_busy[0], 1'b0);
    clear_inputs();
    do_reset();

    // Reset in the middle of a write
    req0 = 1; we0 = 1; addr0 = 7'h22; wdata0 = 8'h99;
    tick();
    chk("t5 bus_we before", o_bus_we[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5 bus_we async", o_bus_we[0], 1'b0);
    chk("t5 bus_drive async", o_bus_drive[0], 1'b0);
    chk("t5 gnt0 async", o_gnt0[0], 1'b0);
    chk("t5 busy async", o_busy[0], 1'b0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t5 no ack", o_ack0[0], 1'b0);
    end

    // WAIT_STATES=0: back-to-back CPU reads of 00 and 01
    do_reset();
    req0 = 1; addr0 = 7'h00; we0 = 0; bus_rdata = 8'h11;
    tick();
    chk("t6 bus_addr 00", o_bus_addr[1], 7'h00);
    tick();
    chk("t6 ack first", o_ack0[1], 1'b1);
    chk("t6 rdata first", o_rdata[1], 8'h11);
    addr0 = 7'h01; bus_rdata = 8'h22;
    tick();
    chk("t6 gap1", o_ack0[1], 1'b0);
    tick();
    chk("t6 gap2", o_ack0[1], 1'b0);
    chk("t6 bus_addr 01", o_bus_addr[1], 7'h01);
    tick();
    chk("t6 ack second", o_ack0[1], 1'b1);
    chk("t6 rdata second", o_rdata[1], 8'h22);
    clear_inputs();
    tick(); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
